// File: rtl/execute_if.sv
// Print output port of the execute stage: a character stream with valid/ready flow control.
interface execute_if;
  logic       print_valid;
  logic [7:0] print_data;
  logic       print_ready;

  modport master (output print_valid, output print_data, input print_ready);
  modport slave  (input print_valid, input print_data, output print_ready);
endinterface

// File: rtl/execute.sv
// Execute/writeback stage: ALU writeback into the shared register file, BRZ resolution,
// and a stalling PRINT port; one stage register set between select and the effects.
module execute #(
  parameter int NCORES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            ins_in,
  input  logic [15:0]            ptr_in,
  input  logic [15:0]            val_in,
  input  logic [NCORES*35-1:0]   rf_in,
  output logic [NCORES*35-1:0]   rf_out,
  output logic                   branch_en,
  output logic [15:0]            branch_addr,
  output logic                   alu_stall,
  execute_if.master              print_bus,
  output logic                   wb_err,
  output logic [31:0]            retired_count
);
  localparam int         EW       = 35;
  localparam logic [3:0] OP_PLUS  = 4'h1;
  localparam logic [3:0] OP_MINUS = 4'h2;
  localparam logic [3:0] OP_BRZ   = 4'h5;
  localparam logic [3:0] OP_PRINT = 4'h9;

  logic [15:0] s_ins_r;
  logic [15:0] s_ptr_r;
  logic [15:0] s_val_r;
  logic [3:0]  opcode_s;
  logic [15:0] imm_s;
  logic        is_alu_s;
  logic        hit_s;
  logic [15:0] res_s;

  assign opcode_s = s_ins_r[15:12];
  assign imm_s    = {4'h0, s_ins_r[11:0]};
  assign is_alu_s = (opcode_s == OP_PLUS) || (opcode_s == OP_MINUS);

  // Everything downstream is decoded from the stage registers, so reset clears it all.
  assign print_bus.print_valid = (opcode_s == OP_PRINT);
  assign print_bus.print_data  = print_bus.print_valid ? s_val_r[7:0] : 8'h00;
  assign alu_stall             = print_bus.print_valid && !print_bus.print_ready;
  assign branch_en             = (opcode_s == OP_BRZ) && (s_val_r == 16'h0000);
  assign branch_addr           = branch_en ? imm_s : 16'h0000;

  // ALU result for the instruction currently in stage.
  always_comb begin
    case (opcode_s)
      OP_PLUS:  res_s = s_val_r + imm_s;
      OP_MINUS: res_s = s_val_r - imm_s;
      default:  res_s = 16'h0000;
    endcase
  end

  // Writeback into the lowest valid+locked entry whose tag matches the data pointer.
  always_comb begin
    rf_out = rf_in;
    hit_s  = 1'b0;
    if (is_alu_s) begin
      for (int i = 0; i < NCORES; i++) begin
        if (!hit_s && rf_in[i*EW + 34] && rf_in[i*EW + 32] &&
            (rf_in[i*EW + 16 +: 16] == s_ptr_r)) begin
          hit_s                  = 1'b1;
          rf_out[i*EW +: 16]     = res_s;
          rf_out[i*EW + 32]      = 1'b0;
        end else begin
          hit_s = hit_s;
        end
      end
    end else begin
      hit_s = 1'b0;
    end
  end

  // Stage registers, retire counter and sticky writeback-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ins_r       <= 16'h0000;
      s_ptr_r       <= 16'h0000;
      s_val_r       <= 16'h0000;
      retired_count <= 32'h0000_0000;
      wb_err        <= 1'b0;
    end else begin
      if (!alu_stall) begin
        s_ins_r <= ins_in;
        s_ptr_r <= ptr_in;
        s_val_r <= val_in;
        if (s_ins_r != 16'h0000) begin
          retired_count <= retired_count + 32'd1;
        end
      end
      if (is_alu_s && !hit_s) begin
        wb_err <= 1'b1;
      end
    end
  end
endmodule
